acs_survivor_packer: RTL and testbench
======================================

# acs_survivor_packer

Parametrised successor to the two-deep ACS survivor buffer. Collects `PACK` consecutive `N_ACS`-bit survivor vectors from the ACS array into one RAM-wide word. Queues completed words in a small FIFO and presents them to the traceback RAM writer over a req/ack handshake, with a circular write address. Sits between the ACS array and the survivor RAM. Adds flush of partial words, back-pressure, address wrap and overflow reporting.

## Interface
- `N_ACS`, default 4: survivor bits per trellis step.
- `PACK`, default 2: survivor vectors per RAM word; must be ≥ 2.
- `RAM_DEPTH`, default 64: RAM words; must be a power of 2.
- `FIFO_DEPTH`, default 4: packed-word queue entries; must be a power of 2 and ≥ 2.
- `Clock1`  in  1  single clock; all state updates on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Active`  in  1  decoder enabled; gates survivor acceptance only.
- `SurvRDY`  in  1  `Survivors` valid this cycle.
- `Survivors`  in  N_ACS  survivor decision vector.
- `Flush`  in  1  one-cycle request to emit the current partial word.
- `RamWrReq`  out  1  `WrittenSurvivors` and `RamWrAddr` valid.
- `RamWrAck`  in  1  RAM writer accepts the head word.
- `WrittenSurvivors`  out  N_ACS*PACK  packed word at FIFO head.
- `RamWrAddr`  out  log2(RAM_DEPTH)  write address for the head word.
- `WrapPulse`  out  1  one cycle high when the address wraps to 0.
- `Overflow`  out  1  sticky: a completed word was dropped.
- `Level`  out  log2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Accept a survivor when `Active & SurvRDY`. Write it into slot `slot` of the pack register: bits [slot*N_ACS +: N_ACS]. The first vector goes to the LSBs and the newest to the MSBs. With PACK=2 the word is {current, previous}.
- On acceptance with `slot==PACK-1`, push the assembled word including the current vector into the FIFO. Clear the pack register and reset `slot` to 0. Otherwise increment `slot`.
- `Flush` with `slot>0` pushes the partial word with unfilled slots zero, then resets `slot` to 0.
- `Flush` with `slot==0` and no acceptance does nothing.
- `Flush` in the same cycle as an acceptance:
  - The vector is included first.
  - Exactly one word is pushed, whether full or partial.
- `Active` low: survivors are ignored and `slot` and the pack register hold. `Flush` is still honoured and FIFO draining continues.
- Push when `Level==FIFO_DEPTH` and no pop that cycle:
  - The word is dropped and the FIFO is unchanged.
  - `Overflow` is set and stays set until `Reset`.
- Push and pop in the same cycle while full are legal. `Level` is unchanged and no overflow is raised.
- `RamWrReq = (Level != 0)`. A pop occurs when `RamWrReq & RamWrAck`.
- `RamWrAck` while `RamWrReq` is low is ignored.
- Each pop increments `RamWrAddr` modulo `RAM_DEPTH`. The pop that takes `RAM_DEPTH-1` to 0 asserts `WrapPulse` for the following cycle.

## Timing
- Reset state: all outputs 0, `slot`=0, pack register 0, FIFO empty. Reset mid-operation discards partial and queued words immediately, regardless of clock.
- Push latency is 1 cycle. If the edge at cycle n completes a word, then after that edge `RamWrReq` is high and `WrittenSurvivors` shows the word, provided the FIFO was empty.
- Pop: after the acknowledged edge, head, address and `Level` show the next entry. Full throughput is one word per cycle when `RamWrAck` is held high.
- `WrittenSurvivors` and `RamWrAddr` are stable while `RamWrReq` is high and `RamWrAck` is low.
- All outputs are registered or decoded directly from registers. There is no combinational path from any input to any output.

## Structure
- Shared package `viterbi_pkg` holds the `N_ACS` and `WD_RAM_DATA` defaults, the `clog2` function and the default `PACK`, `RAM_DEPTH` and `FIFO_DEPTH` values.
- Sub-module `survivor_fifo` (width `N_ACS*PACK`, depth `FIFO_DEPTH`):
  - Synchronous push/pop, with `Clock1` and `Reset` as above.
  - Outputs `Level`, full and empty.
- The packer, address counter and overflow/wrap logic live in the top module.

## Test plan
- PACK=2: accept 4'b1010 then 4'b0101 with `RamWrAck`=0 -> after 2nd edge, `RamWrReq`=1, `WrittenSurvivors`=8'h5A, `RamWrAddr`=0, `Level`=1.
- PACK=4: accept 4'h1, 4'h2, then assert `Flush` -> pushed word 16'h0021. The next three vectors 4'h3, 4'h4, 4'h5 pack from slot 0 with no word pushed; a fourth vector 4'h6 completes 16'h6543.
- `RamWrAck` held 0: push 5 words with FIFO_DEPTH=4 -> `Level`=4 and `Overflow`=1. The head is still the first word, and the dropped fifth word never appears.
- `RamWrAck` held 1 with RAM_DEPTH=4: stream 6 words -> addresses 0,1,2,3,0,1. `WrapPulse` is high for exactly one cycle, after the pop at address 3.
- `Active`=0 mid-word with `SurvRDY` toggling -> `slot` and `Level` are unchanged. After re-enable, packing resumes in the correct slot.
- Assert `Reset` low asynchronously with FIFO half full -> all outputs 0 before the next `Clock1` edge, and `Overflow` cleared.

Source files
------------

// File: rtl/viterbi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// viterbi_pkg : shared Viterbi decoder defaults and width helper
// Rev 1.0
// ---------------------------------------------------------------------------
package viterbi_pkg;

  localparam int DEF_N_ACS      = 4;
  localparam int DEF_PACK       = 2;
  localparam int WD_RAM_DATA    = DEF_N_ACS * DEF_PACK;
  localparam int DEF_RAM_DEPTH  = 64;
  localparam int DEF_FIFO_DEPTH = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/acs_survivor_packer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// acs_survivor_packer_if : ACS-side survivor input and RAM-writer handshake
// Rev 1.0
// ---------------------------------------------------------------------------
interface acs_survivor_packer_if
  import viterbi_pkg::*;
#(
  parameter int N_ACS      = DEF_N_ACS,
  parameter int PACK       = DEF_PACK,
  parameter int RAM_DEPTH  = DEF_RAM_DEPTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);

  logic                          Active;
  logic                          SurvRDY;
  logic [N_ACS-1:0]              Survivors;
  logic                          Flush;
  logic                          RamWrReq;
  logic                          RamWrAck;
  logic [N_ACS*PACK-1:0]         WrittenSurvivors;
  logic [clog2(RAM_DEPTH)-1:0]   RamWrAddr;
  logic                          WrapPulse;
  logic                          Overflow;
  logic [clog2(FIFO_DEPTH):0]    Level;

  modport master (
    input  Active, SurvRDY, Survivors, Flush, RamWrAck,
    output RamWrReq, WrittenSurvivors, RamWrAddr, WrapPulse, Overflow, Level
  );

  modport slave (
    output Active, SurvRDY, Survivors, Flush, RamWrAck,
    input  RamWrReq, WrittenSurvivors, RamWrAddr, WrapPulse, Overflow, Level
  );

endinterface
`default_nettype wire

// File: rtl/acs_survivor_packer_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// survivor_fifo : packed-word queue, synchronous push/pop, head shown when non-empty
// Rev 1.0
// ---------------------------------------------------------------------------
module survivor_fifo
  import viterbi_pkg::*;
#(
  parameter int WIDTH = WD_RAM_DATA,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   Clock1,
  input  logic                   Reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [clog2(DEPTH):0]  level,
  output logic                   full,
  output logic                   empty
);

  localparam int c_ptr_w = clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_level;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_level == (c_ptr_w+1)'(DEPTH));
  assign empty     = (r_level == '0);
  assign w_do_pop  = pop & ~empty;
  // A full queue still takes a word when the head leaves in the same cycle
  assign w_do_push = push & (~full | w_do_pop);
  assign level     = r_level;
  assign rd_data   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge Clock1 or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (c_ptr_w+1)'(1);
        2'b01:   r_level <= r_level - (c_ptr_w+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge Clock1) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/acs_survivor_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// acs_survivor_packer : packs survivor vectors into RAM words, queues them and
//                       hands them to the RAM writer with a circular address
// Rev 1.0
// ---------------------------------------------------------------------------
module acs_survivor_packer
  import viterbi_pkg::*;
#(
  parameter int N_ACS      = DEF_N_ACS,
  parameter int PACK       = DEF_PACK,
  parameter int RAM_DEPTH  = DEF_RAM_DEPTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  Clock1,
  input  logic                  Reset,
  acs_survivor_packer_if.master bus
);

  localparam int c_word_w = N_ACS * PACK;
  localparam int c_slot_w = clog2(PACK);
  localparam int c_addr_w = clog2(RAM_DEPTH);
  localparam int c_lvl_w  = clog2(FIFO_DEPTH) + 1;
  localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(PACK - 1);
  localparam logic [c_addr_w-1:0] c_addr_last = c_addr_w'(RAM_DEPTH - 1);

  logic [c_word_w-1:0] r_pack;
  logic [c_slot_w-1:0] r_slot;
  logic [c_addr_w-1:0] r_addr;
  logic                r_wrap;
  logic                r_overflow;
  logic [c_word_w-1:0] w_merged;
  logic [c_word_w-1:0] w_push_word;
  logic [c_word_w-1:0] w_head;
  logic [c_lvl_w-1:0]  w_level;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;

  assign w_accept = bus.Active & bus.SurvRDY;

  always_comb begin
    w_merged = r_pack;
    w_merged[r_slot*N_ACS +: N_ACS] = bus.Survivors;
  end

  // One push per cycle: a completing vector and a flush share the same word
  assign w_push      = (w_accept & (r_slot == c_slot_last)) |
                       (bus.Flush & (w_accept | (r_slot != '0)));
  assign w_push_word = w_accept ? w_merged : r_pack;
  assign w_pop       = ~w_empty & bus.RamWrAck;

  always_ff @(posedge Clock1 or negedge Reset) begin
    if (!Reset) begin
      r_pack <= '0;
      r_slot <= '0;
    end else if (w_push) begin
      r_pack <= '0;
      r_slot <= '0;
    end else if (w_accept) begin
      r_pack <= w_merged;
      r_slot <= r_slot + c_slot_w'(1);
    end
  end

  always_ff @(posedge Clock1 or negedge Reset) begin
    if (!Reset) begin
      r_addr     <= '0;
      r_wrap     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) r_addr <= r_addr + c_addr_w'(1);
      r_wrap     <= w_pop & (r_addr == c_addr_last);
      r_overflow <= r_overflow | (w_push & w_full & ~w_pop);
    end
  end

  survivor_fifo #(
    .WIDTH (c_word_w),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock1  (Clock1),
    .Reset   (Reset),
    .push    (w_push),
    .wr_data (w_push_word),
    .pop     (w_pop),
    .rd_data (w_head),
    .level   (w_level),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign bus.RamWrReq         = ~w_empty;
  assign bus.WrittenSurvivors = w_head;
  assign bus.RamWrAddr        = r_addr;
  assign bus.WrapPulse        = r_wrap;
  assign bus.Overflow         = r_overflow;
  assign bus.Level            = w_level;

endmodule
`default_nettype wire

// File: tb/tb_acs_survivor_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_acs_survivor_packer : scoreboard bench for two packer configurations
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_acs_survivor_packer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wrap_count = 0;

  logic [7:0]  qa[$];
  logic [15:0] qb[$];
  logic [1:0]  exp_addr;
  logic        exp_wrap;

  acs_survivor_packer_if #(.N_ACS(4), .PACK(2), .RAM_DEPTH(4),  .FIFO_DEPTH(4)) ifa();
  acs_survivor_packer_if #(.N_ACS(4), .PACK(4), .RAM_DEPTH(64), .FIFO_DEPTH(4)) ifb();

  acs_survivor_packer #(.N_ACS(4), .PACK(2), .RAM_DEPTH(4), .FIFO_DEPTH(4)) dut_a (
    .Clock1 (clk),
    .Reset  (rst_n),
    .bus    (ifa)
  );

  acs_survivor_packer #(.N_ACS(4), .PACK(4), .RAM_DEPTH(64), .FIFO_DEPTH(4)) dut_b (
    .Clock1 (clk),
    .Reset  (rst_n),
    .bus    (ifb)
  );

  always #5 clk = ~clk;

  // Pop-side scoreboard for DUT A: word, address and wrap pulse
  initial begin
    logic [7:0] exp_word;
    exp_addr = '0;
    exp_wrap = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_addr = '0;
        exp_wrap = 1'b0;
      end else begin
        checks++;
        if (ifa.WrapPulse !== exp_wrap) begin
          errors++;
          $display("FAIL wrap_pulse: got %b expected %b at %0t", ifa.WrapPulse, exp_wrap, $time);
        end
        if (ifa.WrapPulse === 1'b1) wrap_count++;
        exp_wrap = 1'b0;
        if (ifa.RamWrReq === 1'b1 && ifa.RamWrAck === 1'b1) begin
          exp_wrap = (exp_addr == 2'd3);
          checks++;
          if (qa.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got word %h with empty scoreboard", ifa.WrittenSurvivors);
          end else begin
            exp_word = qa.pop_front();
            if (ifa.WrittenSurvivors !== exp_word || ifa.RamWrAddr !== exp_addr) begin
              errors++;
              $display("FAIL pop_word: got %h@%0d expected %h@%0d", ifa.WrittenSurvivors,
                       ifa.RamWrAddr, exp_word, exp_addr);
            end
          end
          exp_addr = exp_addr + 2'd1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic act, input logic rdy, input logic [3:0] s,
                         input logic fl, input logic ack);
    ifa.Active = act; ifa.SurvRDY = rdy; ifa.Survivors = s; ifa.Flush = fl; ifa.RamWrAck = ack;
  endtask

  task automatic drive_b(input logic act, input logic rdy, input logic [3:0] s,
                         input logic fl, input logic ack);
    ifb.Active = act; ifb.SurvRDY = rdy; ifb.Survivors = s; ifb.Flush = fl; ifb.RamWrAck = ack;
  endtask

  task automatic apply_reset();
    drive_a(0, 0, 4'h0, 0, 0);
    drive_b(0, 0, 4'h0, 0, 0);
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    qa.delete();
    qb.delete();
    cyc();
  endtask

  task automatic test_reset();
    drive_a(0, 0, 4'h0, 0, 0);
    drive_b(0, 0, 4'h0, 0, 0);
    #12;
    checks++;
    if ({ifa.RamWrReq, ifa.WrittenSurvivors, ifa.RamWrAddr, ifa.WrapPulse, ifa.Overflow, ifa.Level} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs_a: got %h expected 0", {ifa.RamWrReq, ifa.WrittenSurvivors,
               ifa.RamWrAddr, ifa.WrapPulse, ifa.Overflow, ifa.Level});
    end
    checks++;
    if ({ifb.RamWrReq, ifb.WrittenSurvivors, ifb.Overflow, ifb.Level} !== 21'h0) begin
      errors++;
      $display("FAIL reset_outputs_b: got %h expected 0", {ifb.RamWrReq, ifb.WrittenSurvivors,
               ifb.Overflow, ifb.Level});
    end
    @(negedge clk); #2 rst_n = 1'b1;
    cyc();
    checks++;
    if (ifa.RamWrReq !== 1'b0 || ifa.Level !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: got req %b level %0d expected 0 0", ifa.RamWrReq, ifa.Level);
    end
  endtask

  task automatic test_pack2();
    drive_a(1, 1, 4'hA, 0, 0); cyc();
    checks++;
    if (ifa.Level !== 3'd0 || ifa.RamWrReq !== 1'b0) begin
      errors++;
      $display("FAIL pack2_half: got level %0d req %b expected 0 0", ifa.Level, ifa.RamWrReq);
    end
    drive_a(1, 1, 4'h5, 0, 0); qa.push_back(8'h5A); cyc();
    drive_a(0, 0, 4'h0, 0, 0);
    checks++;
    if (ifa.RamWrReq !== 1'b1 || ifa.WrittenSurvivors !== 8'h5A) begin
      errors++;
      $display("FAIL pack2_word: got req %b word %h expected 1 5a", ifa.RamWrReq, ifa.WrittenSurvivors);
    end
    checks++;
    if (ifa.RamWrAddr !== 2'd0 || ifa.Level !== 3'd1) begin
      errors++;
      $display("FAIL pack2_addr_level: got %0d/%0d expected 0/1", ifa.RamWrAddr, ifa.Level);
    end
    drive_a(0, 0, 4'h0, 0, 1); cyc();
    drive_a(0, 0, 4'h0, 0, 0);
    checks++;
    if (ifa.Level !== 3'd0 || ifa.RamWrReq !== 1'b0) begin
      errors++;
      $display("FAIL pack2_drain: got level %0d req %b expected 0 0", ifa.Level, ifa.RamWrReq);
    end
  endtask

  task automatic test_full_push_pop();
    for (int w = 0; w < 4; w++) begin
      drive_a(1, 1, 4'(w + 1), 0, 0); cyc();
      drive_a(1, 1, 4'(w + 8), 0, 0); qa.push_back({4'(w + 8), 4'(w + 1)}); cyc();
    end
    drive_a(0, 0, 4'h0, 0, 0);
    checks++;
    if (ifa.Level !== 3'd4 || ifa.Overflow !== 1'b0 || ifa.WrittenSurvivors !== 8'h81) begin
      errors++;
      $display("FAIL full_state: got level %0d ovf %b head %h expected 4 0 81", ifa.Level,
               ifa.Overflow, ifa.WrittenSurvivors);
    end
    drive_a(1, 1, 4'hE, 0, 0); cyc();
    drive_a(1, 1, 4'hF, 0, 1); qa.push_back(8'hFE); cyc();
    drive_a(0, 0, 4'h0, 0, 0);
    checks++;
    if (ifa.Level !== 3'd4 || ifa.Overflow !== 1'b0 || ifa.WrittenSurvivors !== 8'h92) begin
      errors++;
      $display("FAIL full_push_pop: got level %0d ovf %b head %h expected 4 0 92", ifa.Level,
               ifa.Overflow, ifa.WrittenSurvivors);
    end
    drive_a(0, 0, 4'h0, 0, 1); repeat (6) cyc();
    drive_a(0, 0, 4'h0, 0, 0);
    checks++;
    if (ifa.Level !== 3'd0 || qa.size() != 0) begin
      errors++;
      $display("FAIL full_drain: got level %0d pending %0d expected 0 0", ifa.Level, qa.size());
    end
  endtask

  task automatic test_active_gate();
    drive_a(1, 1, 4'h3, 0, 0); cyc();
    for (int i = 0; i < 4; i++) begin
      drive_a(0, i[0], 4'(i + 5), 0, 0); cyc();
      checks++;
      if (ifa.Level !== 3'd0 || ifa.RamWrReq !== 1'b0) begin
        errors++;
        $display("FAIL gate_hold: got level %0d req %b expected 0 0", ifa.Level, ifa.RamWrReq);
      end
    end
    drive_a(1, 1, 4'hC, 0, 0); qa.push_back(8'hC3); cyc();
    drive_a(0, 0, 4'h0, 0, 0);
    checks++;
    if (ifa.Level !== 3'd1 || ifa.WrittenSurvivors !== 8'hC3) begin
      errors++;
      $display("FAIL gate_resume: got level %0d head %h expected 1 c3", ifa.Level, ifa.WrittenSurvivors);
    end
    drive_a(0, 0, 4'h0, 0, 1); cyc();
    drive_a(0, 0, 4'h0, 0, 0);
  endtask

  task automatic test_stream_wrap();
    apply_reset();
    wrap_count = 0;
    for (int k = 0; k < 12; k++) begin
      drive_a(1, 1, 4'(k + 3), 0, 1);
      if (k % 2 == 1) qa.push_back({4'(k + 3), 4'(k + 2)});
      cyc();
    end
    drive_a(0, 0, 4'h0, 0, 1); repeat (3) cyc();
    drive_a(0, 0, 4'h0, 0, 0);
    checks++;
    if (wrap_count != 1) begin
      errors++;
      $display("FAIL wrap_count: got %0d expected 1", wrap_count);
    end
    checks++;
    if (ifa.RamWrAddr !== 2'd2 || ifa.Level !== 3'd0 || qa.size() != 0) begin
      errors++;
      $display("FAIL stream_end: got addr %0d level %0d pending %0d expected 2 0 0",
               ifa.RamWrAddr, ifa.Level, qa.size());
    end
  endtask

  task automatic test_flush_pack4();
    logic [15:0] exp_word;
    drive_b(1, 1, 4'h1, 0, 0); cyc();
    drive_b(1, 1, 4'h2, 0, 0); cyc();
    drive_b(0, 0, 4'h0, 1, 0); qb.push_back(16'h0021); cyc();
    drive_b(0, 0, 4'h0, 0, 0);
    checks++;
    if (ifb.Level !== 3'd1 || ifb.WrittenSurvivors !== 16'h0021) begin
      errors++;
      $display("FAIL flush_partial: got level %0d head %h expected 1 0021", ifb.Level, ifb.WrittenSurvivors);
    end
    for (int v = 3; v <= 5; v++) begin
      drive_b(1, 1, 4'(v), 0, 0); cyc();
      checks++;
      if (ifb.Level !== 3'd1) begin
        errors++;
        $display("FAIL flush_refill: got level %0d expected 1", ifb.Level);
      end
    end
    drive_b(1, 1, 4'h6, 0, 0); qb.push_back(16'h6543); cyc();
    drive_b(0, 0, 4'h0, 1, 0); cyc();
    checks++;
    if (ifb.Level !== 3'd2) begin
      errors++;
      $display("FAIL flush_empty_slot: got level %0d expected 2", ifb.Level);
    end
    drive_b(1, 1, 4'h7, 1, 0); qb.push_back(16'h0007); cyc();
    drive_b(0, 1, 4'h9, 1, 0); cyc();
    drive_b(0, 0, 4'h0, 0, 1);
    checks++;
    if (ifb.Level !== 3'd3) begin
      errors++;
      $display("FAIL flush_with_accept: got level %0d expected 3", ifb.Level);
    end
    for (int i = 0; i < 3; i++) begin
      exp_word = qb.pop_front();
      checks++;
      if (ifb.WrittenSurvivors !== exp_word || ifb.RamWrAddr !== 6'(i)) begin
        errors++;
        $display("FAIL pack4_pop: got %h@%0d expected %h@%0d", ifb.WrittenSurvivors,
                 ifb.RamWrAddr, exp_word, i);
      end
      cyc();
    end
    drive_b(0, 0, 4'h0, 0, 0);
    checks++;
    if (ifb.Level !== 3'd0 || ifb.RamWrReq !== 1'b0) begin
      errors++;
      $display("FAIL pack4_drain: got level %0d req %b expected 0 0", ifb.Level, ifb.RamWrReq);
    end
  endtask

  task automatic test_overflow();
    for (int w = 0; w < 5; w++) begin
      if (w == 4) begin
        checks++;
        if (ifa.Level !== 3'd4 || ifa.Overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_pre: got level %0d ovf %b expected 4 0", ifa.Level, ifa.Overflow);
        end
      end
      drive_a(1, 1, 4'(w + 1), 0, 0); cyc();
      drive_a(1, 1, 4'(w + 10), 0, 0);
      if (w < 4) qa.push_back({4'(w + 10), 4'(w + 1)});
      cyc();
    end
    drive_a(0, 0, 4'h0, 0, 0);
    checks++;
    if (ifa.Level !== 3'd4 || ifa.Overflow !== 1'b1 || ifa.WrittenSurvivors !== 8'hA1) begin
      errors++;
      $display("FAIL ovf_post: got level %0d ovf %b head %h expected 4 1 a1", ifa.Level,
               ifa.Overflow, ifa.WrittenSurvivors);
    end
  endtask

  task automatic test_async_reset();
    drive_a(0, 0, 4'h0, 0, 1); cyc(); cyc();
    drive_a(0, 0, 4'h0, 0, 0);
    checks++;
    if (ifa.Level !== 3'd2 || ifa.Overflow !== 1'b1) begin
      errors++;
      $display("FAIL half_full: got level %0d ovf %b expected 2 1", ifa.Level, ifa.Overflow);
    end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifa.RamWrReq, ifa.WrittenSurvivors, ifa.RamWrAddr, ifa.WrapPulse, ifa.Overflow, ifa.Level} !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", {ifa.RamWrReq, ifa.WrittenSurvivors,
               ifa.RamWrAddr, ifa.WrapPulse, ifa.Overflow, ifa.Level});
    end
    qa.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    cyc();
    checks++;
    if (ifa.Level !== 3'd0 || ifa.Overflow !== 1'b0 || ifa.RamWrReq !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got level %0d ovf %b req %b expected 0 0 0", ifa.Level,
               ifa.Overflow, ifa.RamWrReq);
    end
  endtask

  initial begin
    test_reset();
    test_pack2();
    test_full_push_pop();
    test_active_gate();
    test_stream_wrap();
    test_flush_pack4();
    test_overflow();
    test_async_reset();
    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
